scaler_video_out: RTL and testbench
===================================

Name: scaler_video_out

Overview:
- Downstream sink of streamScaler.
- Pulls scaled pixels through the scaler's dOut/dOutValid/nextDout handshake into a small prefetch FIFO.
- Drives raster timing (RGB, hsync, vsync, data enable) for the display port of the mlx90640 thermal-camera pipeline.
- Detects FIFO underrun in active video and re-aligns the stream during vertical blanking, so frame boundaries stay locked to the scaler output.

Parameters:
- DATA_WIDTH, 8, bits per colour channel
- CHANNELS, 3, colour channels per pixel
- FIFO_DEPTH, 8, prefetch FIFO entries (power of 2, >=4)
- PREFILL, 4, FIFO level required before timing starts (1..FIFO_DEPTH)
- H_ACTIVE / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48, horizontal timing in clocks
- V_ACTIVE / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33, vertical timing in lines
- HS_POL / VS_POL, 0 / 0, sync active level (0 = active-low)

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  run request; level-sensitive
- dOut  in  DATA_WIDTH*CHANNELS  pixel from scaler
- dOutValid  in  1  dOut valid this cycle
- nextDout  out  1  sink ready; a transfer occurs on any cycle where nextDout && dOutValid
- rgb  out  DATA_WIDTH*CHANNELS  pixel to display
- de  out  1  active-video enable
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- frameStart  out  1  one-cycle pulse coincident with first active pixel of each frame
- clearStatus  in  1  synchronous clear of underrun and underrunCnt
- underrun  out  1  sticky underrun flag
- underrunCnt  out  16  saturating count of substituted pixels

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; FIFO empty; hCnt=vCnt=0; missing=0.
  - rgb=0, de=0, frameStart=0, nextDout=0, underrun=0, underrunCnt=0.
  - hsync=~HS_POL, vsync=~VS_POL.
- Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Both counters are 12-bit.
- FIFO:
  - nextDout = (state!=IDLE) && (count<FIFO_DEPTH), combinational from registered count.
  - Push on nextDout && dOutValid. Simultaneous push and pop is legal; count is unchanged.
- States:
  - IDLE: on enable=1, go to PREFILL.
  - PREFILL: counters held at 0, outputs blank. When count>=PREFILL, go to RUN. The first RUN cycle has hCnt=0, vCnt=0.
  - RUN: hCnt increments each clock and wraps at H_TOTAL-1 to 0. On wrap, vCnt increments and wraps at V_TOTAL-1.
  - Any state: enable=0 returns to IDLE next cycle, flushes the FIFO, clears missing and counters, and blanks outputs. Upstream must restart the scaler. Status counters are kept.
- Active slot (RUN, hCnt<H_ACTIVE, vCnt<V_ACTIVE):
  - FIFO non-empty: pop; the popped pixel appears on rgb the next cycle.
  - FIFO empty: rgb=0 next cycle; missing+=1; underrun=1; underrunCnt+=1, saturating at 16'hFFFF.
- Blanking slot (vCnt>=V_ACTIVE):
  - If missing>0 and FIFO non-empty, pop and discard, missing-=1.
  - Restores alignment before the next frame. Popping never occurs during horizontal blanking of active lines.
- Latency: all outputs are registered, one cycle after the counter state that produces them.
  - de = active slot.
  - hsync active when H_ACTIVE+H_FP <= hCnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync active when V_ACTIVE+V_FP <= vCnt < V_ACTIVE+V_FP+V_SYNC.
  - frameStart = (hCnt==0 && vCnt==0 in RUN).
- missing is 16-bit saturating. If missing is still >0 when vCnt wraps, it is carried into the next frame's blanking.
- clearStatus has priority over a same-cycle increment: the result is 0.

Test Plan:
1. Small timing (H 8/2/2/2, V 4/1/1/1, PREFILL=4), source always valid:
   - first de 1 cycle after RUN entry;
   - 32 de pixels per frame, in source order;
   - hsync low at hCnt 10-11;
   - vsync low on line 5;
   - frameStart every 14*7=98 cycles;
   - underrun stays 0.
2. Source valid every other cycle (same timing): underrun=1 with the correct underrunCnt, and missing pixels are discarded during vertical blanking. Frame 2's first de pixel equals source pixel index 32.
3. FIFO full with dOutValid held high, timing in blanking: nextDout=0 exactly while count==FIFO_DEPTH; no pixel is lost or duplicated (compare sequence numbers).
4. enable dropped mid-line:
   - next cycle: de=0, nextDout=0, FIFO empty;
   - re-enable: PREFILL, then frame restarts at hCnt=0, vCnt=0.
5. rst asserted mid-frame: all outputs take their reset values asynchronously, before the next clock edge.
6. Underrun forced past 65535 slots: underrunCnt saturates at 16'hFFFF. clearStatus in the same cycle as an underrun yields 0.

Source files
------------

// File: rtl/scaler_video_out_if.sv
// rtl/scaler_video_out_if.sv - scaler pixel handshake (dOut/dOutValid/nextDout)
interface scaler_video_out_if #(
  parameter int W = 24
) ();
  logic [W-1:0] dOut;
  logic         dOutValid;
  logic         nextDout;

  // The scaler drives pixels; the video sink answers with nextDout.
  modport master (output dOut, output dOutValid, input nextDout);
  modport slave  (input dOut, input dOutValid, output nextDout);
endinterface

// File: rtl/scaler_video_out.sv
// rtl/scaler_video_out.sv - prefetch FIFO and raster timing for scaled video output
module scaler_video_out #(
  parameter int   DATA_WIDTH = 8,
  parameter int   CHANNELS   = 3,
  parameter int   FIFO_DEPTH = 8,
  parameter int   PREFILL    = 4,
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter logic HS_POL     = 1'b0,
  parameter logic VS_POL     = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  scaler_video_out_if.slave              src,
  output logic [DATA_WIDTH*CHANNELS-1:0] rgb,
  output logic                           de,
  output logic                           hsync,
  output logic                           vsync,
  output logic                           frameStart,
  input  logic                           clearStatus,
  output logic                           underrun,
  output logic [15:0]                    underrunCnt
);
  localparam int PW = DATA_WIDTH * CHANNELS;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [11:0] H_ACT     = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_LO = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_HI = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST    = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_ACT     = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_LO = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_HI = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST    = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PREFILL_C = CW'(PREFILL);

  typedef enum logic [1:0] {ST_IDLE, ST_PREFILL, ST_RUN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [11:0]     h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [15:0]     missing_q, missing_d;
  logic [PW-1:0]   rgb_q, rgb_d;
  logic            de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic            frame_start_q, frame_start_d;
  logic            underrun_q, underrun_d;
  logic [15:0]     underrun_cnt_q, underrun_cnt_d;

  logic [PW-1:0]   fifo_mem [FIFO_DEPTH];

  logic ready, push, pop, run, active_slot, vblank_slot, fifo_empty;
  logic show, starve, discard, h_sync_on, v_sync_on;

  // Slot decode: everything is gated by enable so a drop blanks on the next edge.
  assign ready       = (state_q != ST_IDLE) && (count_q < DEPTH_C);
  assign push        = ready && src.dOutValid;
  assign run         = (state_q == ST_RUN) && enable;
  assign active_slot = run && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign vblank_slot = run && (v_cnt_q >= V_ACT);
  assign fifo_empty  = (count_q == '0);
  assign show        = active_slot && !fifo_empty;
  assign starve      = active_slot && fifo_empty;
  // Pixels owed to substituted slots are dropped only in vertical blanking,
  // so each frame restarts on the scaler's own frame boundary.
  assign discard     = vblank_slot && (missing_q != 16'd0) && !fifo_empty;
  assign pop         = show || discard;
  assign h_sync_on   = run && (h_cnt_q >= H_SYNC_LO) && (h_cnt_q < H_SYNC_HI);
  assign v_sync_on   = run && (v_cnt_q >= V_SYNC_LO) && (v_cnt_q < V_SYNC_HI);

  assign src.nextDout = ready;
  assign rgb          = rgb_q;
  assign de           = de_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign frameStart   = frame_start_q;
  assign underrun     = underrun_q;
  assign underrunCnt  = underrun_cnt_q;

  // Next-state: FIFO bookkeeping, sequencer, raster counters, registered outputs.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    missing_d = missing_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_PREFILL;
      end
      ST_PREFILL: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (count_q >= PREFILL_C) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (h_cnt_q == H_LAST) begin
          h_cnt_d = '0;
          v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
        end else begin
          h_cnt_d = h_cnt_q + 12'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (starve && (missing_q != 16'hFFFF)) missing_d = missing_q + 16'd1;
    else if (discard)                      missing_d = missing_q - 16'd1;

    // Dropping enable abandons the stream; the scaler is restarted upstream.
    if (!enable) begin
      state_d   = ST_IDLE;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      h_cnt_d   = '0;
      v_cnt_d   = '0;
      missing_d = '0;
    end

    rgb_d         = show ? fifo_mem[rd_ptr_q] : '0;
    de_d          = active_slot;
    hsync_d       = h_sync_on ? HS_POL : ~HS_POL;
    vsync_d       = v_sync_on ? VS_POL : ~VS_POL;
    frame_start_d = run && (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);

    underrun_d     = underrun_q;
    underrun_cnt_d = underrun_cnt_q;
    if (clearStatus) begin
      underrun_d     = 1'b0;
      underrun_cnt_d = '0;
    end else if (starve) begin
      underrun_d = 1'b1;
      if (underrun_cnt_q != 16'hFFFF) underrun_cnt_d = underrun_cnt_q + 16'd1;
    end
  end

  // FIFO storage needs no reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= src.dOut;
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      h_cnt_q        <= '0;
      v_cnt_q        <= '0;
      missing_q      <= '0;
      rgb_q          <= '0;
      de_q           <= 1'b0;
      hsync_q        <= ~HS_POL;
      vsync_q        <= ~VS_POL;
      frame_start_q  <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      h_cnt_q        <= h_cnt_d;
      v_cnt_q        <= v_cnt_d;
      missing_q      <= missing_d;
      rgb_q          <= rgb_d;
      de_q           <= de_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      frame_start_q  <= frame_start_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end
endmodule

// File: tb/tb_scaler_video_out.sv
// tb/tb_scaler_video_out.sv - self-checking bench for scaler_video_out
module tb_scaler_video_out;
  localparam int DEPTH = 8;
  localparam int PRE   = 4;
  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int RUN_T0 = 6;
  localparam logic [45:0] RESET_VEC = {24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};

  logic clk = 1'b0;
  logic rst, enable, clear;
  logic [23:0] rgb;
  logic de, hsync, vsync, frame_start, underrun;
  logic [15:0] ucnt;

  logic rst2, en2, clr2;
  logic [23:0] rgb2;
  logic de2, hsync2, vsync2, frame_start2, underrun2;
  logic [15:0] ucnt2;

  scaler_video_out_if #(.W(24)) sv_if ();
  scaler_video_out_if #(.W(24)) sv_if2 ();

  scaler_video_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FIFO_DEPTH(DEPTH), .PREFILL(PRE)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .src(sv_if),
    .rgb(rgb), .de(de), .hsync(hsync), .vsync(vsync), .frameStart(frame_start),
    .clearStatus(clear), .underrun(underrun), .underrunCnt(ucnt)
  );

  scaler_video_out #(
    .H_ACTIVE(200), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(200), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .FIFO_DEPTH(DEPTH), .PREFILL(PRE)
  ) dut_sat (
    .clk(clk), .rst(rst2), .enable(en2), .src(sv_if2),
    .rgb(rgb2), .de(de2), .hsync(hsync2), .vsync(vsync2), .frameStart(frame_start2),
    .clearStatus(clr2), .underrun(underrun2), .underrunCnt(ucnt2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: FIFO as a queue, raster position from elapsed run time.
  int ph;
  int t;
  int missing;
  logic [23:0] q[$];
  logic m_urun;
  logic [15:0] m_ucnt;
  logic [23:0] e_rgb;
  logic e_de, e_hs, e_vs, e_fs;

  task automatic model_reset();
    ph = 0; t = 0; missing = 0; q.delete();
    m_urun = 1'b0; m_ucnt = 16'h0;
    e_rgb = 24'h0; e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic val, input logic clr, input logic [23:0] din);
    int n;
    int h;
    int v;
    logic rdy;
    logic starve;
    logic [23:0] dummy;
    n = q.size();
    rdy = (ph != 0) && (n < DEPTH);
    starve = 1'b0;
    e_rgb = 24'h0; e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
    if (!en) begin
      ph = 0; q.delete(); missing = 0; t = 0;
    end else begin
      if (ph == 2) begin
        h = t % HT;
        v = (t / HT) % VT;
        if (h < HA && v < VA) begin
          e_de = 1'b1;
          if (n > 0) e_rgb = q.pop_front();
          else begin
            starve = 1'b1;
            if (missing < 65535) missing++;
          end
        end else if (v >= VA && missing > 0 && n > 0) begin
          dummy = q.pop_front();
          missing--;
        end
        e_hs = (h >= HA + HF && h < HA + HF + HS) ? 1'b0 : 1'b1;
        e_vs = (v >= VA + VF && v < VA + VF + VS) ? 1'b0 : 1'b1;
        e_fs = (h == 0 && v == 0);
        t++;
      end else if (ph == 1) begin
        if (n >= PRE) begin ph = 2; t = 0; end
      end else begin
        ph = 1;
      end
      if (rdy && val) q.push_back(din);
    end
    if (clr) begin
      m_urun = 1'b0; m_ucnt = 16'h0;
    end else if (starve) begin
      m_urun = 1'b1;
      if (m_ucnt != 16'hFFFF) m_ucnt++;
    end
  endtask

  int src_idx = 0;
  int tick_no = 0;
  logic [23:0] s_rgb;
  logic s_de, s_hs, s_vs, s_fs, s_nd, s_ur;
  logic [15:0] s_uc;
  logic [23:0] h_rgb [512];
  logic [3:0]  h_flags [512];

  function automatic logic [45:0] dut_vec();
    return {rgb, de, hsync, vsync, frame_start, sv_if.nextDout, underrun, ucnt};
  endfunction

  // One clock: drive inputs, compare everything at the falling edge, advance the model.
  task automatic tick(input logic en, input logic val, input logic clr);
    logic m_ready;
    enable = en; sv_if.dOutValid = val; sv_if.dOut = 24'(src_idx); clear = clr;
    @(negedge clk);
    m_ready = (ph != 0) && (q.size() < DEPTH);
    s_rgb = rgb; s_de = de; s_hs = hsync; s_vs = vsync; s_fs = frame_start;
    s_nd = sv_if.nextDout; s_ur = underrun; s_uc = ucnt;
    check("cycle", dut_vec(), {e_rgb, e_de, e_hs, e_vs, e_fs, m_ready, m_urun, m_ucnt});
    if (tick_no < 512) begin
      h_rgb[tick_no] = rgb;
      h_flags[tick_no] = {de, hsync, vsync, frame_start};
    end
    tick_no++;
    model_step(en, val, clr, 24'(src_idx));
    if (s_nd && val) src_idx++;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int f;
    int h;
    int v;
    logic [23:0] rgb;
    logic [3:0] flags;
  } tvec_t;

  tvec_t tbl [14];

  // Second instance: four pixels then a dry source, to drive underrunCnt to saturation.
  initial begin : src2
    int sent;
    logic xfer;
    sent = 0;
    rst2 = 1'b0; en2 = 1'b0;
    sv_if2.dOutValid = 1'b0; sv_if2.dOut = 24'h0;
    repeat (2) @(posedge clk);
    #1;
    rst2 = 1'b1; en2 = 1'b1; sv_if2.dOutValid = 1'b1;
    for (int i = 0; i < 20 && sent < 4; i++) begin
      @(negedge clk);
      xfer = sv_if2.nextDout && sv_if2.dOutValid;
      @(posedge clk);
      #1;
      if (xfer) begin
        sent++;
        sv_if2.dOut = 24'(sent);
        if (sent == 4) sv_if2.dOutValid = 1'b0;
      end
    end
    sv_if2.dOutValid = 1'b0;
  end

  initial begin : main
    int nd_low;
    int de_cnt;
    int nfs;
    int fs_at;
    int idx;
    logic found;
    logic prev;

    tbl[0]  = '{0, 0, 0, 24'd0,  4'b1111};
    tbl[1]  = '{0, 7, 0, 24'd7,  4'b1110};
    tbl[2]  = '{0, 8, 0, 24'd0,  4'b0110};
    tbl[3]  = '{0, 10, 0, 24'd0, 4'b0010};
    tbl[4]  = '{0, 11, 3, 24'd0, 4'b0010};
    tbl[5]  = '{0, 12, 1, 24'd0, 4'b0110};
    tbl[6]  = '{0, 5, 2, 24'd21, 4'b1110};
    tbl[7]  = '{0, 0, 4, 24'd0,  4'b0110};
    tbl[8]  = '{0, 3, 5, 24'd0,  4'b0100};
    tbl[9]  = '{0, 10, 5, 24'd0, 4'b0000};
    tbl[10] = '{0, 13, 6, 24'd0, 4'b0110};
    tbl[11] = '{1, 0, 0, 24'd32, 4'b1111};
    tbl[12] = '{1, 9, 3, 24'd0,  4'b0110};
    tbl[13] = '{0, -1, 0, 24'd0, 4'b0110};

    rst = 1'b0; enable = 1'b0; clear = 1'b0; clr2 = 1'b0;
    sv_if.dOutValid = 1'b0; sv_if.dOut = 24'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_vec(), RESET_VEC);
    rst = 1'b1;

    // Always-valid source: timing table, pixel order, full-FIFO backpressure.
    nd_low = 0;
    for (int i = 0; i < 210; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      if (i > RUN_T0 && !s_nd) nd_low++;
    end
    for (int i = 0; i < 14; i++) begin
      idx = RUN_T0 + 1 + tbl[i].f * HT * VT + tbl[i].v * HT + tbl[i].h;
      check($sformatf("tbl%0d", i), {h_rgb[idx], h_flags[idx]}, {tbl[i].rgb, tbl[i].flags});
    end
    de_cnt = 0;
    for (int i = 0; i < HT * VT; i++) de_cnt += int'(h_flags[RUN_T0 + 1 + i][3]);
    check("de_per_frame", de_cnt, 32);
    check("no_underrun", s_ur, 1'b0);
    check("backpressure_seen", (nd_low > 0), 1'b1);

    // Half-rate source: underruns, then realignment in vertical blanking.
    tick(1'b0, 1'b0, 1'b0);
    src_idx = 0;
    nfs = 0;
    for (int i = 0; i < 3 * HT * VT + 20; i++) begin
      tick(1'b1, (i % 2) == 1, 1'b0);
      if (s_fs) begin
        nfs++;
        if (nfs == 2) check("frame2_first_pixel", s_rgb, 24'd32);
      end
    end
    check("frames_seen", (nfs >= 3), 1'b1);
    check("underrun_set", s_ur, 1'b1);

    // Random source with occasional status clears.
    for (int i = 0; i < 400; i++)
      tick(1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);

    // Enable dropped mid-line, then restart from an empty FIFO.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      found = s_de;
    end
    check("active_found", found, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    src_idx = 0;
    tick(1'b1, 1'b1, 1'b0);
    check("disable_blank", {s_de, s_nd}, 2'b00);
    fs_at = 0;
    for (int i = 1; i <= 30 && fs_at == 0; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      if (s_fs) fs_at = i;
    end
    check("restart_latency", fs_at, 7);
    check("restart_first_pixel", s_rgb, 24'd0);

    // Asynchronous reset while hsync is active.
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick(1'b1, $urandom_range(0, 1) == 1, 1'b0);
      found = !s_hs;
    end
    check("hsync_found", found, 1'b1);
    rst = 1'b0;
    #2;
    check("async_reset", dut_vec(), RESET_VEC);
    model_reset();
    #1;
    rst = 1'b1;
    src_idx = 0;
    for (int i = 0; i < 150; i++) tick(1'b1, $urandom_range(0, 2) != 0, 1'b0);

    // Saturation and clear priority on the second instance.
    for (int i = 0; i < 80000 && ucnt2 !== 16'hFFFF; i++) @(negedge clk);
    check("sat_reach", ucnt2, 16'hFFFF);
    repeat (300) @(negedge clk);
    check("sat_hold", {underrun2, ucnt2}, {1'b1, 16'hFFFF});
    found = 1'b0;
    prev = de2;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      found = !prev && de2;
      prev = de2;
    end
    check("de2_rise_found", found, 1'b1);
    clr2 = 1'b1;
    @(posedge clk);
    #1;
    clr2 = 1'b0;
    @(negedge clk);
    check("clear_priority", {underrun2, ucnt2}, 17'h0);
    @(negedge clk);
    check("count_after_clear", {underrun2, ucnt2}, {1'b1, 16'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
